// File: rtl/phase_pkg.sv
// -----------------------------------------------------------------------------
// phase_pkg
//   Shared types and helpers for the phase reconstruction path.
//   - phase_t            : default signed phase word (full scale = +/-pi)
//   - PHASE_MAX/PHASE_MIN: extreme codes of phase_t
//   - integ_state_t      : integrator control state (IDLE / RUN)
//   - wrap_add()         : modular three-term phase add with wrap detection
// -----------------------------------------------------------------------------
package phase_pkg;

  localparam int PHASE_W = 18;

  typedef logic signed [PHASE_W-1:0] phase_t;

  localparam phase_t PHASE_MAX = {1'b0, {(PHASE_W-1){1'b1}}};
  localparam phase_t PHASE_MIN = {1'b1, {(PHASE_W-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } integ_state_t;

  // Container width for wrap_add operands; callers sign-extend their phase
  // words into it, so any phase width below ADD_W is supported.
  localparam int ADD_W = 32;

  localparam logic [1:0] WRAP_NONE = 2'b00;
  localparam logic [1:0] WRAP_POS  = 2'b01;
  localparam logic [1:0] WRAP_NEG  = 2'b10;

  typedef struct packed {
    logic signed [ADD_W-1:0] phase;  // wrapped result, sign-extended from w bits
    logic [1:0]              wrap;   // WRAP_NONE / WRAP_POS / WRAP_NEG
  } wrap_sum_t;

  // Adds three w-bit signed phase words (sign-extended to ADD_W) modulo 2^w.
  // The exact sum is folded back into w bits; if folding changed the value
  // the sum left the +/-pi range, and the sign of the exact sum tells which
  // way. Three w-bit terms can exceed the range by less than one full turn,
  // so at most one wrap is reported per add.
  function automatic wrap_sum_t wrap_add(input logic signed [ADD_W-1:0] a,
                                         input logic signed [ADD_W-1:0] b,
                                         input logic signed [ADD_W-1:0] c,
                                         input int                      w);
    logic signed [ADD_W+1:0] sum;
    logic signed [ADD_W+1:0] folded;
    int                      sh;
    wrap_sum_t               r;
    sum    = {{2{a[ADD_W-1]}}, a} + {{2{b[ADD_W-1]}}, b} + {{2{c[ADD_W-1]}}, c};
    sh     = ADD_W + 2 - w;
    folded = (sum <<< sh) >>> sh;
    r.phase = folded[ADD_W-1:0];
    if (folded == sum) begin
      r.wrap = WRAP_NONE;
    end else if (sum[ADD_W+1]) begin
      r.wrap = WRAP_NEG;
    end else begin
      r.wrap = WRAP_POS;
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_integrator_sat_updown_counter.sv
// -----------------------------------------------------------------------------
// sat_updown_counter
//   Signed up/down counter that saturates at +(2^(W-1)-1) and -2^(W-1).
//   clr restarts the count from zero in the same cycle, and a simultaneous
//   inc/dec is applied on top of that zero.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   inc, dec    : single-step up / down requests (both high = no change)
//   clr         : restart from zero
//   count       : signed registered count
// -----------------------------------------------------------------------------
module sat_updown_counter #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                dec,
  input  logic                clr,
  output logic signed [W-1:0] count
);

  localparam logic signed [W-1:0] CNT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] CNT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  function automatic logic signed [W-1:0] sat_step(input logic signed [W-1:0] c,
                                                   input logic                up,
                                                   input logic                dn);
    logic signed [W-1:0] n;
    n = c;
    if (up && !dn && (c != CNT_MAX)) begin
      n = c + CNT_ONE;
    end else if (dn && !up && (c != CNT_MIN)) begin
      n = c - CNT_ONE;
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= sat_step('0, inc, dec);
    end else begin
      count <= sat_step(count, inc, dec);
    end
  end

endmodule

// File: rtl/phase_integrator.sv
// -----------------------------------------------------------------------------
// phase_integrator
//   Rebuilds absolute phase from signed phase increments (inverse of the
//   post-CORDIC phase differentiator). Arithmetic wraps modulo 2*pi; each
//   crossing of +/-pi is flagged and tallied in a saturating revolution count.
//
// Optional build macro: PHASE_INTEG_FREQ_OFFSET_EN
//   Adds input freq_offset, summed into every accepted sample (also while
//   frozen). Without the macro the port is absent and the offset is zero.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   delta_valid  : delta_theta carries a sample this cycle
//   delta_theta  : signed phase increment
//   load_en      : replace the accumulator base with load_phase
//   load_phase   : signed phase to load
//   freeze       : accepted samples integrate as zero increment
//   freq_offset  : (macro only) signed per-sample phase offset
//   theta        : registered reconstructed phase
//   theta_valid  : theta updated this cycle (registered delta_valid)
//   wrap_pos     : one-cycle pulse, crossed +pi -> -pi
//   wrap_neg     : one-cycle pulse, crossed -pi -> +pi
//   rev_cnt      : signed saturating net revolution count
//   running      : a sample has been accepted since reset / last load
//
// WIDTH must stay below phase_pkg::ADD_W.
// -----------------------------------------------------------------------------
module phase_integrator
  import phase_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int REV_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    delta_valid,
  input  logic signed [WIDTH-1:0] delta_theta,
  input  logic                    load_en,
  input  logic signed [WIDTH-1:0] load_phase,
  input  logic                    freeze,
`ifdef PHASE_INTEG_FREQ_OFFSET_EN
  input  logic signed [WIDTH-1:0] freq_offset,
`endif
  output logic signed [WIDTH-1:0] theta,
  output logic                    theta_valid,
  output logic                    wrap_pos,
  output logic                    wrap_neg,
  output logic signed [REV_W-1:0] rev_cnt,
  output logic                    running
);

  logic signed [WIDTH-1:0] acc_p1;
  logic signed [WIDTH-1:0] theta_p1;
  logic                    vld_p1;
  logic                    wrap_pos_p1;
  logic                    wrap_neg_p1;

  logic signed [WIDTH-1:0] base_p0;
  logic signed [WIDTH-1:0] inc_p0;
  logic signed [WIDTH-1:0] offs_p0;
  logic signed [WIDTH-1:0] sum_p0;
  logic                    wrap_pos_p0;
  logic                    wrap_neg_p0;
  wrap_sum_t               ws_p0;
  logic                    unused_hi_p0;

  integ_state_t            state;
  integ_state_t            state_nxt;

`ifdef PHASE_INTEG_FREQ_OFFSET_EN
  assign offs_p0 = freq_offset;
`else
  assign offs_p0 = '0;
`endif

  // ---- stage p0: base/increment selection and modular add ----
  always_comb begin
    base_p0     = load_en ? load_phase : acc_p1;
    inc_p0      = freeze ? '0 : delta_theta;
    ws_p0       = wrap_add(ADD_W'(base_p0), ADD_W'(inc_p0), ADD_W'(offs_p0), WIDTH);
    sum_p0      = ws_p0.phase[WIDTH-1:0];
    // Wraps only count for accepted samples; a bare load never wraps.
    wrap_pos_p0 = delta_valid && (ws_p0.wrap == WRAP_POS);
    wrap_neg_p0 = delta_valid && (ws_p0.wrap == WRAP_NEG);
  end

  // Upper container bits are just the sign extension of sum_p0.
  assign unused_hi_p0 = ^ws_p0.phase[ADD_W-1:WIDTH];

  // ---- stage p1: accumulator and output registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p1      <= '0;
      theta_p1    <= '0;
      vld_p1      <= 1'b0;
      wrap_pos_p1 <= 1'b0;
      wrap_neg_p1 <= 1'b0;
    end else begin
      vld_p1      <= delta_valid;
      wrap_pos_p1 <= wrap_pos_p0;
      wrap_neg_p1 <= wrap_neg_p0;
      if (delta_valid) begin
        acc_p1   <= sum_p0;
        theta_p1 <= sum_p0;
      end else if (load_en) begin
        acc_p1   <= load_phase;
      end
    end
  end

  // Revolution count moves in the same cycle the wrap flags register.
  sat_updown_counter #(
    .W(REV_W)
  ) u_rev_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (wrap_pos_p0),
    .dec  (wrap_neg_p0),
    .clr  (load_en),
    .count(rev_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (delta_valid) begin
      state_nxt = RUN;
    end else if (load_en) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    running = (state == RUN);
  end

  assign theta       = theta_p1;
  assign theta_valid = vld_p1;
  assign wrap_pos    = wrap_pos_p1;
  assign wrap_neg    = wrap_neg_p1;

endmodule
